// File: rtl/conv_sched.sv
// Convolution tile sequencer: loads 64 weight bytes, streams 4-lane feature beats, waits for datapath completion.
// Latency: one cycle from feature acceptance to data_o/lane_valid; done one cycle after conv_done.
// Backpressure: w_ready/f_ready are asserted only in their load/stream phases; the datapath side has none.
module conv_sched #(
    parameter int PIX_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] pix_count,
    input  logic             w_valid,
    input  logic [7:0]       w_data,
    output logic             w_ready,
    input  logic             f_valid,
    input  logic [31:0]      f_data,
    output logic             f_ready,
    output logic [7:0]       data_o_1,
    output logic [7:0]       data_o_2,
    output logic [7:0]       data_o_3,
    output logic [7:0]       data_o_4,
    output logic [3:0]       lane_valid,
    output logic [511:0]     w_flat,
    input  logic             out_ready,
    output logic             bus_free,
    input  logic             conv_done,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // One extra bit so the drain counter can hold TIMEOUT itself without wrapping.
    localparam int DW = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       w_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [PIX_W-1:0] pix_lat;
    logic [DW-1:0]    drain_cnt;
    logic             w_acc;
    logic             f_acc;
    logic             w_last;
    logic             f_last;
    logic             drain_to;

    assign w_acc    = (state == S_LOAD_W) && w_valid;
    assign f_acc    = (state == S_STREAM) && f_valid;
    assign w_last   = w_acc && (w_cnt == 6'd63);
    assign f_last   = f_acc && (pix_cnt == pix_lat - PIX_W'(1));
    assign drain_to = (drain_cnt == DW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (pix_count == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (w_last) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (f_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (conv_done || drain_to) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (state == S_LOAD_W);
        f_ready = (state == S_STREAM);
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt      <= '0;
            pix_cnt    <= '0;
            pix_lat    <= '0;
            drain_cnt  <= '0;
            w_flat     <= '0;
            data_o_1   <= '0;
            data_o_2   <= '0;
            data_o_3   <= '0;
            data_o_4   <= '0;
            lane_valid <= '0;
            bus_free   <= 1'b0;
            err        <= 1'b0;
        end else begin
            lane_valid <= '0;
            // Grant reflects the state being entered so it lines up with the cycle it is observed in.
            bus_free   <= out_ready && ((state_nxt == S_STREAM) || (state_nxt == S_DRAIN));
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pix_lat <= pix_count;
                        err     <= 1'b0;
                        w_cnt   <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (w_acc) begin
                        w_flat[{w_cnt, 3'b000} +: 8] <= w_data;
                        w_cnt <= w_cnt + 6'd1;
                        if (w_last) begin
                            pix_cnt <= '0;
                        end
                    end
                end
                S_STREAM: begin
                    if (f_acc) begin
                        data_o_1   <= f_data[31:24];
                        data_o_2   <= f_data[23:16];
                        data_o_3   <= f_data[15:8];
                        data_o_4   <= f_data[7:0];
                        lane_valid <= 4'hF;
                        pix_cnt    <= pix_cnt + PIX_W'(1);
                        if (f_last) begin
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    // A completion arriving on the timeout cycle still counts as clean.
                    if (drain_to && !conv_done) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched with a phase-level reference model checked every cycle.
module tb_conv_sched;

    localparam int PIX_W   = 16;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [PIX_W-1:0] pix_count = '0;
    logic             w_valid = 1'b0;
    logic [7:0]       w_data = '0;
    logic             w_ready;
    logic             f_valid = 1'b0;
    logic [31:0]      f_data = '0;
    logic             f_ready;
    logic [7:0]       data_o_1, data_o_2, data_o_3, data_o_4;
    logic [3:0]       lane_valid;
    logic [511:0]     w_flat;
    logic             out_ready = 1'b0;
    logic             bus_free;
    logic             conv_done = 1'b0;
    logic             busy, done, err;

    conv_sched #(.PIX_W(PIX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_count(pix_count),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .f_valid(f_valid), .f_data(f_data), .f_ready(f_ready),
        .data_o_1(data_o_1), .data_o_2(data_o_2), .data_o_3(data_o_3), .data_o_4(data_o_4),
        .lane_valid(lane_valid), .w_flat(w_flat), .out_ready(out_ready), .bus_free(bus_free),
        .conv_done(conv_done), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit en     = 0;
    logic [31:0] beats[$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_LOAD, P_STREAM, P_DRAIN, P_DONE} ph_t;
    ph_t  ph = P_IDLE;
    int   bytes_got = 0, beats_left = 0, drain_elapsed = 0;
    logic [7:0] wt[64];
    logic [7:0] m_data[4];
    logic [3:0] m_lv = 0;
    logic       m_bus = 0, m_err = 0;

    always @(posedge clk or posedge rst) begin
        ph_t nxt;
        if (rst) begin
            ph = P_IDLE; bytes_got = 0; beats_left = 0; drain_elapsed = 0;
            for (int i = 0; i < 64; i++) wt[i] = 8'h00;
            for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
            m_lv = 0; m_bus = 0; m_err = 0;
        end else begin
            nxt  = ph;
            m_lv = 0;
            case (ph)
                P_IDLE: if (start) begin
                    m_err = 0; beats_left = int'(pix_count); bytes_got = 0;
                    nxt = (pix_count == 0) ? P_DONE : P_LOAD;
                end
                P_LOAD: if (w_valid) begin
                    wt[bytes_got] = w_data;
                    bytes_got++;
                    if (bytes_got == 64) nxt = P_STREAM;
                end
                P_STREAM: if (f_valid) begin
                    for (int l = 0; l < 4; l++) m_data[l] = f_data[31-8*l -: 8];
                    m_lv = 4'hF;
                    beats_left--;
                    if (beats_left == 0) begin nxt = P_DRAIN; drain_elapsed = 0; end
                end
                P_DRAIN: begin
                    drain_elapsed++;
                    if (conv_done) nxt = P_DONE;
                    else if (drain_elapsed == TIMEOUT) begin m_err = 1; nxt = P_DONE; end
                end
                P_DONE: nxt = P_IDLE;
                default: nxt = P_IDLE;
            endcase
            m_bus = out_ready && (nxt == P_STREAM || nxt == P_DRAIN);
            ph = nxt;
        end
    end

    always @(negedge clk) begin
        logic [511:0] exp_w;
        for (int i = 0; i < 64; i++) exp_w[i*8 +: 8] = wt[i];
        if (en) begin
            chk("w_flat",     w_flat,     exp_w);
            chk("data_o_1",   data_o_1,   m_data[0]);
            chk("data_o_2",   data_o_2,   m_data[1]);
            chk("data_o_3",   data_o_3,   m_data[2]);
            chk("data_o_4",   data_o_4,   m_data[3]);
            chk("lane_valid", lane_valid, m_lv);
            chk("bus_free",   bus_free,   m_bus);
            chk("err",        err,        m_err);
            chk("busy",       busy,       ph != P_IDLE);
            chk("done",       done,       ph == P_DONE);
            chk("w_ready",    w_ready,    ph == P_LOAD);
            chk("f_ready",    f_ready,    ph == P_STREAM);
        end
        if (lane_valid == 4'hF) beats.push_back({data_o_1, data_o_2, data_o_3, data_o_4});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        out_ready = (cyc % 3) != 0;
    endtask

    task automatic begin_tile(input int n);
        start = 1; pix_count = PIX_W'(n);
        tick();
        start = 0;
    endtask

    task automatic load_weights(input int first, input int nbytes, input int base, input int gap);
        for (int i = first; i < first + nbytes; i++) begin
            bit acc = 0;
            int guard = 0;
            w_valid = 0;
            for (int g = 0; g < gap; g++) tick();
            w_valid = 1; w_data = 8'(base + i);
            while (!acc && guard < 20) begin acc = w_ready; tick(); guard++; end
            if (!acc) bound_fail("w_accept");
        end
        w_valid = 0;
    endtask

    task automatic send_beat(input logic [31:0] d, input int gap);
        bit acc = 0;
        int guard = 0;
        f_valid = 0;
        for (int g = 0; g < gap; g++) tick();
        f_valid = 1; f_data = d;
        while (!acc && guard < 20) begin acc = f_ready; tick(); guard++; end
        if (!acc) bound_fail("f_accept");
        f_valid = 0;
    endtask

    task automatic finish_tile();
        tick(); tick();
        conv_done = 1;
        tick();
        conv_done = 0;
        chk("done_after_conv_done", done, 1'b1);
        tick();
        chk("busy_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        repeat (3) tick();
        en = 1;
        chk("reset_w_flat", w_flat, 512'd0);
        chk("reset_busy", busy, 1'b0);
        rst = 0;
        tick(); tick();

        // Tile 1: ramp weights, three beats
        beats.delete();
        begin_tile(3);
        chk("busy_after_start", busy, 1'b1);
        chk("w_ready_after_start", w_ready, 1'b1);
        load_weights(0, 64, 0, 0);
        chk("stream_entered", f_ready, 1'b1);
        send_beat(32'h01020304, 0);
        send_beat(32'h05060708, 0);
        send_beat(32'h090A0B0C, 0);
        finish_tile();
        for (int n = 0; n < 64; n += 21) chk("w_flat_ramp_byte", w_flat[n*8 +: 8], 8'(n));
        chk("t1_beat_count", beats.size(), 3);
        if (beats.size() == 3) begin
            chk("t1_beat0", beats[0], 32'h01020304);
            chk("t1_beat2", beats[2], 32'h090A0B0C);
        end
        tick();

        // Tile 2: throttled weights, gapped features
        beats.delete();
        begin_tile(4);
        load_weights(0, 64, 8'h40, 2);
        chk("t2_byte63", w_flat[511:504], 8'h7F);
        chk("t2_byte17", w_flat[143:136], 8'h51);
        for (int b = 0; b < 4; b++) send_beat(32'hA0B0C0D0 + 32'(b), 1 + b);
        finish_tile();
        chk("t2_beat_count", beats.size(), 4);
        if (beats.size() == 4) chk("t2_beat3", beats[3], 32'hA0B0C0D3);

        // Tile 3: timeout, then a zero-pixel start clears err
        begin_tile(1);
        load_weights(0, 64, 8'h10, 0);
        send_beat(32'h11223344, 0);
        begin
            int n = 0;
            while (!done && n < 100) begin tick(); n++; end
            if (!done) bound_fail("timeout_done");
            chk("timeout_drain_cycles", n, 16);
            chk("timeout_err", err, 1'b1);
        end
        tick();
        chk("err_sticky_idle", err, 1'b1);
        begin_tile(0);
        chk("zero_pix_done", done, 1'b1);
        chk("zero_pix_err_cleared", err, 1'b0);
        chk("zero_pix_no_w_ready", w_ready, 1'b0);
        tick();
        chk("zero_pix_idle", busy, 1'b0);

        // Tile 4: reset in the middle of the weight load
        begin_tile(2);
        load_weights(0, 30, 8'hC0, 0);
        rst = 1;
        tick(); tick();
        chk("midreset_w_flat", w_flat, 512'd0);
        chk("midreset_busy", busy, 1'b0);
        rst = 0;
        tick();
        beats.delete();
        begin_tile(2);
        load_weights(0, 64, 8'h80, 0);
        send_beat(32'hDEADBEEF, 0);
        send_beat(32'h0BADF00D, 0);
        finish_tile();
        chk("t4_byte0", w_flat[7:0], 8'h80);
        chk("t4_beat_count", beats.size(), 2);

        // Tile 5: start and conv_done pulses during STREAM are ignored
        beats.delete();
        begin_tile(3);
        load_weights(0, 64, 8'h20, 0);
        send_beat(32'h01010101, 0);
        start = 1; pix_count = 1; conv_done = 1;
        tick(); tick();
        start = 0; conv_done = 0;
        chk("stream_held", f_ready, 1'b1);
        send_beat(32'h02020202, 0);
        chk("stream_still", f_ready, 1'b1);
        send_beat(32'h03030303, 0);
        finish_tile();
        chk("t5_beat_count", beats.size(), 3);
        repeat (4) tick();

        en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/conv_sched.md
# conv_sched

Sequencing controller for the convolution post-processing datapath. It loads the 4×16 signed 8-bit weight set from a byte stream, then streams packed 4-lane feature words into the datapath with per-lane valids. It gates the datapath's output-bus grant (`bus_free`) and waits for the datapath's `conv_done` before reporting tile completion. It sits between the DMA/host streams and the conv_post datapath, one instance per datapath.

## Interface
- `PIX_W`, 16, width of the per-tile pixel count
- `TIMEOUT`, 4096, maximum DRAIN cycles before forced completion with error
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: tile start pulse; sampled only in IDLE
- `pix_count` in PIX_W: pixels per lane for the tile; latched on accepted `start`
- `w_valid` in 1 / `w_data` in 8 / `w_ready` out 1: weight byte stream
- `f_valid` in 1 / `f_data` in 32 / `f_ready` out 1: feature stream; lane1=[31:24] … lane4=[7:0]
- `data_o_1..4` out 8 each: lane feature bytes to the datapath
- `lane_valid` out 4: per-lane valid; bit0=lane1 … bit3=lane4
- `w_flat` out 512: weights; byte for lane L (0..3), tap T (A..P = 0..15) at bits [(L*16+T)*8 +: 8]
- `out_ready` in 1: downstream can take datapath output
- `bus_free` out 1: grant to the datapath output stage
- `conv_done` in 1: datapath completion pulse
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle tile completion pulse
- `err` out 1: sticky timeout flag; cleared by the next accepted `start`

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE. Next state is registered.
- IDLE
  - `start`=1: latch `pix_count` and clear `err`.
  - If the latched count is 0, go to DONE. Otherwise go to LOAD_W with `w_cnt`=0.
- LOAD_W
  - `w_ready`=1.
  - Each `w_valid&w_ready` writes `w_data` to byte `w_cnt` of `w_flat`, then increments `w_cnt` (6 bits). Byte order is lane1 A..P, lane2 A..P, lane3, lane4.
  - Acceptance of byte 63 moves to STREAM with `pix_cnt`=0.
- STREAM
  - `f_ready`=1. The datapath has no backpressure.
  - Each `f_valid` beat registers the four lane bytes into `data_o_1..4`, pulses `lane_valid`=4'hF for that one cycle, and increments `pix_cnt`.
  - Acceptance of beat `pix_count`-1 moves to DRAIN with the drain counter at 0.
  - Cycles without `f_valid`: `lane_valid`=0 and `data_o_*` hold their last value.
- DRAIN
  - Waits for `conv_done`, then goes to DONE.
  - The drain counter increments each cycle. When it reaches TIMEOUT-1 without `conv_done`, set `err`=1 and go to DONE.
  - `conv_done` on the same cycle as the timeout wins: `err` stays 0.
- DONE: `done`=1 for this one cycle, then IDLE.
- `bus_free` is registered: it equals `out_ready` from the previous cycle when the current state is STREAM or DRAIN, and 0 otherwise.
- `w_flat` is written only in LOAD_W and is stable throughout STREAM and DRAIN.
- `start` outside IDLE is ignored. `conv_done` outside DRAIN is ignored.
- `w_ready` is 0 outside LOAD_W; `f_ready` is 0 outside STREAM.
- Counters do not wrap: each transition fires on exact terminal-count equality.

## Timing
- Reset values: all outputs 0 (`w_flat`, `data_o_*`, `lane_valid`, `bus_free`, `busy`, `done`, `err`, `w_ready`, `f_ready`); state IDLE; all counters 0.
- `rst` asserted mid-operation returns to IDLE immediately and clears the weights. Any partial load or stream is discarded.
- `start` high at edge k moves the block to LOAD_W. `busy` and `w_ready` are high from cycle k+1.
- Minimum load time is 64 cycles, one byte per cycle. STREAM is entered the cycle after byte 63 is accepted.
- Feature latency: a beat accepted at edge t appears on `data_o_*`/`lane_valid` in cycle t+1.
- `conv_done` sampled at edge d gives `done`=1 in cycle d+1, and the block is in IDLE (`busy`=0) in cycle d+2.
- `pix_count`=0: `start` at edge k gives `done` in cycle k+1 with no weight load.

## Test plan
- Reset, then load weights 0x00..0x3F and stream pix_count=3 beats 0x01020304, 0x05060708, 0x090A0B0C, then pulse `conv_done` → `w_flat` byte n = n; three `lane_valid`=4'hF pulses with `data_o_1..4` = 01/02/03/04, etc.; `done` one cycle after `conv_done`; `busy` drops next cycle.
- Throttled `w_valid` (every 3rd cycle) and gapped `f_valid` → byte order intact; `lane_valid`=0 on gap cycles; exactly `pix_count` pulses.
- Withhold `conv_done` with TIMEOUT=16 → `done` plus `err`=1 after 16 DRAIN cycles; the next `start` clears `err`.
- Assert `rst` in the middle of LOAD_W (byte 30) → all outputs 0 and state IDLE; a subsequent full tile completes correctly.
- `start` with pix_count=0 → `done` in cycle k+1 and `w_ready` never high. `start` pulses during STREAM → ignored, count unchanged.
- Toggle `out_ready` in IDLE, STREAM and DRAIN → `bus_free` follows `out_ready` with a 1-cycle lag only in STREAM/DRAIN and is 0 otherwise. `conv_done` pulsed in STREAM is ignored.
